// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the load/store unit: ls_type
//                encodings, exception cause codes, FSM state encoding,
//                bus widths and the alignment check.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int c_REG_AW    = 5;
    localparam int c_LS_TYPE_W = 4;
    localparam int c_CAUSE_W   = 2;

    // ls_type encodings; bit3 = store, bit2 = unsigned load, bits[1:0] = size
    localparam logic [3:0] c_LS_LB  = 4'b0000;
    localparam logic [3:0] c_LS_LH  = 4'b0001;
    localparam logic [3:0] c_LS_LW  = 4'b0010;
    localparam logic [3:0] c_LS_LBU = 4'b0100;
    localparam logic [3:0] c_LS_LHU = 4'b0101;
    localparam logic [3:0] c_LS_SB  = 4'b1000;
    localparam logic [3:0] c_LS_SH  = 4'b1001;
    localparam logic [3:0] c_LS_SW  = 4'b1010;

    localparam logic [1:0] c_EXC_NONE     = 2'b00;
    localparam logic [1:0] c_EXC_LD_MISAL = 2'b01;
    localparam logic [1:0] c_EXC_ST_MISAL = 2'b10;
    localparam logic [1:0] c_EXC_BUS      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // Halfwords need addr[0]==0, words need addr[1:0]==0, bytes always fit.
    function automatic logic ls_misaligned(input logic [3:0] ls_type,
                                           input logic [1:0] off);
        case (ls_type[1:0])
            2'b00:   ls_misaligned = 1'b0;
            2'b01:   ls_misaligned = off[0];
            default: ls_misaligned = |off;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dalign.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dalign
//  Description : Combinational data aligner. Store side replicates the
//                store data across byte lanes and generates byte strobes;
//                load side extracts the addressed byte/half and extends it.
//  Ports       : i_ls_type  access type
//                i_off      address byte offset (addr[1:0])
//                i_sdata    raw store data (rs2)
//                i_rdata    raw memory read word
//                o_wdata    lane-replicated store data
//                o_wstrb    byte strobes (zero for loads)
//                o_ldata    extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_dalign
    import lsu_pkg::*;
(
    input  logic [c_LS_TYPE_W-1:0] i_ls_type,
    input  logic [1:0]             i_off,
    input  logic [31:0]            i_sdata,
    input  logic [31:0]            i_rdata,
    output logic [31:0]            o_wdata,
    output logic [3:0]             o_wstrb,
    output logic [31:0]            o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_wdata = i_sdata;
        o_wstrb = 4'b0000;
        case (i_ls_type)
            c_LS_SB: begin
                o_wdata = {4{i_sdata[7:0]}};
                o_wstrb = 4'b0001 << i_off;
            end
            c_LS_SH: begin
                o_wdata = {2{i_sdata[15:0]}};
                o_wstrb = 4'b0011 << i_off;
            end
            c_LS_SW: o_wstrb = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        o_ldata = i_rdata;
        case (i_ls_type)
            c_LS_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
            c_LS_LBU: o_ldata = {24'd0, w_byte};
            c_LS_LH:  o_ldata = {{16{w_half[15]}}, w_half};
            c_LS_LHU: o_ldata = {16'd0, w_half};
            c_LS_LW:  o_ldata = i_rdata;
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module      : lsu
//  Description : Load/store unit. Accepts the execute-stage bundle, runs a
//                req/gnt/rvalid data-memory access for aligned loads/stores,
//                and presents a registered one-cycle writeback pulse to wbu.
//  Ports       : ex_*/inst_*/reg_*/csr_*/memory_addr_i/store_data_i/ls_*
//                    execute-stage bundle in, ex_ready_o back-pressure
//                mem_*   data-memory request/response port
//                wb_valid_o, inst_o.. exc_cause_o  registered writeback
//                stallreq_o  pipeline stall while an access is outstanding
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid_i,
    output logic                   ex_ready_o,
    input  logic [31:0]            inst_i,
    input  logic [ADDR_W-1:0]      inst_addr_i,
    input  logic                   reg_we_i,
    input  logic [c_REG_AW-1:0]    reg_waddr_i,
    input  logic [DATA_W-1:0]      reg_wdata_i,
    input  logic [ADDR_W-1:0]      memory_addr_i,
    input  logic [DATA_W-1:0]      store_data_i,
    input  logic                   ls_valid_i,
    input  logic [c_LS_TYPE_W-1:0] ls_type_i,
    input  logic                   csr_we_i,
    input  logic [31:0]            csr_waddr_i,
    input  logic [DATA_W-1:0]      csr_wdata_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    output logic [3:0]             mem_wstrb_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [DATA_W-1:0]      mem_rdata_i,
    input  logic                   mem_err_i,
    output logic                   wb_valid_o,
    output logic [31:0]            inst_o,
    output logic [ADDR_W-1:0]      inst_addr_o,
    output logic                   reg_we_o,
    output logic [c_REG_AW-1:0]    reg_waddr_o,
    output logic [DATA_W-1:0]      reg_wdata_o,
    output logic                   csr_we_o,
    output logic [31:0]            csr_waddr_o,
    output logic [DATA_W-1:0]      csr_wdata_o,
    output logic                   exc_o,
    output logic [c_CAUSE_W-1:0]   exc_cause_o,
    output logic                   stallreq_o
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;

    // Bundle captured for the duration of a bus access
    logic [31:0]            r_inst;
    logic [ADDR_W-1:0]      r_pc;
    logic                   r_reg_we;
    logic [c_REG_AW-1:0]    r_reg_waddr;
    logic [DATA_W-1:0]      r_reg_wdata;
    logic                   r_csr_we;
    logic [31:0]            r_csr_waddr;
    logic [DATA_W-1:0]      r_csr_wdata;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_sdata;
    logic [c_LS_TYPE_W-1:0] r_ls_type;

    logic                 w_accept, w_in_misal, w_done;
    logic                 w_capture, w_fire, w_src_in, w_exc;
    logic [c_CAUSE_W-1:0] w_cause;
    logic                 w_reg_we, w_csr_we;
    logic [DATA_W-1:0]    w_reg_wdata, w_ldata, w_wdata;
    logic [3:0]           w_wstrb;

    assign ex_ready_o = (r_state == ST_IDLE);
    assign w_accept   = ex_valid_i & ex_ready_o;
    assign w_in_misal = ls_misaligned(ls_type_i, memory_addr_i[1:0]);
    assign stallreq_o = (r_state != ST_IDLE) |
                        (ex_valid_i & ls_valid_i & ~w_in_misal);

    // A response in REQ only counts when it arrives together with the grant.
    assign w_done = mem_rvalid_i & ((r_state == ST_WAIT) | mem_gnt_i);

    lsu_dalign u_dalign (
        .i_ls_type (r_ls_type),
        .i_off     (r_addr[1:0]),
        .i_sdata   (r_sdata),
        .i_rdata   (mem_rdata_i),
        .o_wdata   (w_wdata),
        .o_wstrb   (w_wstrb),
        .o_ldata   (w_ldata)
    );

    assign mem_req_o   = (r_state == ST_REQ);
    assign mem_we_o    = mem_req_o & r_ls_type[3];
    assign mem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata_o = w_wdata;
    assign mem_wstrb_o = w_wstrb;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_fire      = 1'b0;
        w_src_in    = 1'b0;
        w_exc       = 1'b0;
        w_cause     = c_EXC_NONE;
        w_reg_we    = 1'b0;
        w_reg_wdata = r_reg_wdata;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_src_in    = 1'b1;
                    w_reg_wdata = reg_wdata_i;
                    if (!ls_valid_i) begin
                        w_fire   = 1'b1;
                        w_reg_we = reg_we_i;
                    end else if (w_in_misal) begin
                        w_fire  = 1'b1;
                        w_exc   = 1'b1;
                        w_cause = ls_type_i[3] ? c_EXC_ST_MISAL : c_EXC_LD_MISAL;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                if (w_done) begin
                    w_fire      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (mem_err_i) begin
                        w_exc   = 1'b1;
                        w_cause = c_EXC_BUS;
                    end else if (!r_ls_type[3]) begin
                        w_reg_we    = r_reg_we;
                        w_reg_wdata = w_ldata;
                    end
                end else if (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_fire      = 1'b1;
                    w_exc       = 1'b1;
                    w_cause     = c_EXC_BUS;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if ((r_state == ST_REQ) && mem_gnt_i) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Exceptions suppress architectural CSR writes as well as GPR writes.
    assign w_csr_we = (w_src_in ? csr_we_i : r_csr_we) & ~w_exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst      <= '0;
            r_pc        <= '0;
            r_reg_we    <= 1'b0;
            r_reg_waddr <= '0;
            r_reg_wdata <= '0;
            r_csr_we    <= 1'b0;
            r_csr_waddr <= '0;
            r_csr_wdata <= '0;
            r_addr      <= '0;
            r_sdata     <= '0;
            r_ls_type   <= '0;
        end else if (w_capture) begin
            r_inst      <= inst_i;
            r_pc        <= inst_addr_i;
            r_reg_we    <= reg_we_i;
            r_reg_waddr <= reg_waddr_i;
            r_reg_wdata <= reg_wdata_i;
            r_csr_we    <= csr_we_i;
            r_csr_waddr <= csr_waddr_i;
            r_csr_wdata <= csr_wdata_i;
            r_addr      <= memory_addr_i;
            r_sdata     <= store_data_i;
            r_ls_type   <= ls_type_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o  <= 1'b0;
            inst_o      <= '0;
            inst_addr_o <= '0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            csr_we_o    <= 1'b0;
            csr_waddr_o <= '0;
            csr_wdata_o <= '0;
            exc_o       <= 1'b0;
            exc_cause_o <= '0;
        end else begin
            wb_valid_o <= w_fire;
            if (w_fire) begin
                inst_o      <= w_src_in ? inst_i      : r_inst;
                inst_addr_o <= w_src_in ? inst_addr_i : r_pc;
                reg_waddr_o <= w_src_in ? reg_waddr_i : r_reg_waddr;
                csr_waddr_o <= w_src_in ? csr_waddr_i : r_csr_waddr;
                csr_wdata_o <= w_src_in ? csr_wdata_i : r_csr_wdata;
                reg_we_o    <= w_reg_we;
                reg_wdata_o <= w_reg_wdata;
                csr_we_o    <= w_csr_we;
                exc_o       <= w_exc;
                exc_cause_o <= w_cause;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu
//  Description : Self-checking bench for lsu: directed cases plus random
//                bundles compared against a behavioural access model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid_i = 1'b0, ex_ready_o;
    logic [31:0] inst_i = '0, inst_addr_i = '0;
    logic        reg_we_i = 1'b0;
    logic [4:0]  reg_waddr_i = '0;
    logic [31:0] reg_wdata_i = '0, memory_addr_i = '0, store_data_i = '0;
    logic        ls_valid_i = 1'b0;
    logic [3:0]  ls_type_i = '0;
    logic        csr_we_i = 1'b0;
    logic [31:0] csr_waddr_i = '0, csr_wdata_i = '0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        wb_valid_o;
    logic [31:0] inst_o, inst_addr_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        csr_we_o;
    logic [31:0] csr_waddr_o, csr_wdata_o;
    logic        exc_o;
    logic [1:0]  exc_cause_o;
    logic        stallreq_o;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(TO), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
        .memory_addr_i(memory_addr_i), .store_data_i(store_data_i),
        .ls_valid_i(ls_valid_i), .ls_type_i(ls_type_i),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .wb_valid_o(wb_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .exc_o(exc_o), .exc_cause_o(exc_cause_o), .stallreq_o(stallreq_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [3:0] t);
        case (t)
            4'h0, 4'h4, 4'h8: return 1;
            4'h1, 4'h5, 4'h9: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] t, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint v;
        int sz, off;
        sz  = m_size(t);
        off = int'(a % 4);
        v   = ({32'd0, rd} >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
        if (!(t == 4'h4 || t == 4'h5) && v >= (64'd1 << (8 * sz - 1)))
            v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] t, input logic [31:0] sd);
        case (m_size(t))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [3:0] t, input logic [31:0] a);
        int v;
        v = ((1 << m_size(t)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    // ---------------- observations for directed checks ----------------
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_wstrb;
    logic        obs_we;
    int          n_req_hi;

    task automatic run_tx(input logic ls, input logic [3:0] t, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdv,
                          input logic rwe, input logic [4:0] rd, input logic [31:0] rwd,
                          input int gd, input int rvd, input logic err);
        logic [31:0] inst, pc, ca, cd;
        logic        cwe, mis, st;
        inst = $urandom; pc = $urandom; ca = $urandom; cd = $urandom;
        cwe  = ls ? 1'b0 : 1'($urandom_range(0, 1));
        st   = t[3];
        mis  = ls && ((a % m_size(t)) != 0);
        inst_i = inst; inst_addr_i = pc; reg_we_i = rwe; reg_waddr_i = rd;
        reg_wdata_i = rwd; memory_addr_i = a; store_data_i = sd;
        ls_valid_i = ls; ls_type_i = t; csr_we_i = cwe; csr_waddr_i = ca;
        csr_wdata_i = cd; ex_valid_i = 1'b1;
        #1;
        chk("ready_acc", ex_ready_o, 1'b1);
        chk("stall_acc", stallreq_o, ls && !mis);
        @(posedge clk); #1;
        ex_valid_i = 1'b0; ls_valid_i = 1'($urandom_range(0, 1));
        inst_i = $urandom; reg_wdata_i = $urandom; memory_addr_i = $urandom;
        n_req_hi = 0;
        if (!ls || mis) begin
            chk("req_none", mem_req_o, 1'b0);
        end else begin
            for (int k = 0; k <= gd; k++) begin
                chk("req_hi", mem_req_o, 1'b1);
                chk("req_addr", mem_addr_o, {a[31:2], 2'b00});
                chk("req_we", mem_we_o, st);
                if (st) begin
                    chk("req_wdata", mem_wdata_o, m_wdata(t, sd));
                    chk("req_wstrb", mem_wstrb_o, m_wstrb(t, a));
                end
                chk("req_stall", stallreq_o, 1'b1);
                chk("req_ready", ex_ready_o, 1'b0);
                chk("req_wbv", wb_valid_o, 1'b0);
                if (k == 0) begin
                    obs_addr = mem_addr_o; obs_wdata = mem_wdata_o;
                    obs_wstrb = mem_wstrb_o; obs_we = mem_we_o;
                end
                n_req_hi += int'(mem_req_o);
                mem_rdata_i = $urandom; mem_err_i = 1'($urandom_range(0, 1));
                if (k == gd) begin
                    mem_gnt_i = 1'b1;
                    if (rvd == 0) begin
                        mem_rvalid_i = 1'b1; mem_rdata_i = rdv; mem_err_i = err;
                    end
                end
                @(posedge clk); #1;
                mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            end
            if (rvd > 0) begin
                for (int k = 1; k < rvd; k++) begin
                    chk("wait_req", mem_req_o, 1'b0);
                    chk("wait_stall", stallreq_o, 1'b1);
                    chk("wait_wbv", wb_valid_o, 1'b0);
                    mem_rdata_i = $urandom; mem_err_i = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                chk("wait_stall", stallreq_o, 1'b1);
                mem_rvalid_i = 1'b1; mem_rdata_i = rdv; mem_err_i = err;
                @(posedge clk); #1;
                mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
            end
        end
        chk("wb_valid", wb_valid_o, 1'b1);
        chk("wb_inst", inst_o, inst);
        chk("wb_pc", inst_addr_o, pc);
        chk("wb_rd", reg_waddr_o, rd);
        if (!ls) begin
            chk("wb_reg_we", reg_we_o, rwe);
            chk("wb_reg_wdata", reg_wdata_o, rwd);
            chk("wb_csr_we", csr_we_o, cwe);
            chk("wb_csr_addr", csr_waddr_o, ca);
            chk("wb_csr_data", csr_wdata_o, cd);
            chk("wb_exc", exc_o, 1'b0);
            chk("wb_cause", exc_cause_o, 2'd0);
        end else if (mis) begin
            chk("wb_reg_we", reg_we_o, 1'b0);
            chk("wb_csr_we", csr_we_o, 1'b0);
            chk("wb_exc", exc_o, 1'b1);
            chk("wb_cause", exc_cause_o, st ? 2'd2 : 2'd1);
        end else begin
            chk("wb_exc", exc_o, err);
            chk("wb_cause", exc_cause_o, err ? 2'd3 : 2'd0);
            chk("wb_reg_we", reg_we_o, (!st && !err) ? rwe : 1'b0);
            if (!st && !err && rwe) chk("wb_load", reg_wdata_o, m_load(t, a, rdv));
            chk("wb_csr_we", csr_we_o, 1'b0);
        end
        @(posedge clk); #1;
        chk("wb_pulse", wb_valid_o, 1'b0);
        chk("wb_hold_rd", reg_waddr_o, rd);
        chk("idle_ready", ex_ready_o, 1'b1);
    endtask

    logic [3:0] types_arr [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a;
        logic [3:0]  t;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wbv", wb_valid_o, 1'b0);
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_we", mem_we_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_wstrb", mem_wstrb_o, 4'd0);
        chk("rst_reg_we", reg_we_o, 1'b0);
        chk("rst_reg_wdata", reg_wdata_o, 32'd0);
        chk("rst_exc", exc_o, 1'b0);
        chk("rst_cause", exc_cause_o, 2'd0);
        chk("rst_stall", stallreq_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed cases
        run_tx(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234, 0, 1, 1'b0);
        chk("nonls_wdata", reg_wdata_o, 32'h1234);
        run_tx(1'b1, 4'h0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b1, 5'd7, 32'h0, 0, 1, 1'b0);
        chk("lb_addr", obs_addr, 32'h8000_0000);
        chk("lb_data", reg_wdata_o, 32'hFFFF_FF80);
        run_tx(1'b1, 4'h4, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b1, 5'd7, 32'h0, 0, 1, 1'b0);
        chk("lbu_data", reg_wdata_o, 32'h0000_0080);
        run_tx(1'b1, 4'h9, 32'h8000_0002, 32'hAAAA_BEEF, 32'h0, 1'b1, 5'd3, 32'h0, 0, 1, 1'b0);
        chk("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
        chk("sh_wstrb", obs_wstrb, 4'b1100);
        chk("sh_we", obs_we, 1'b1);
        chk("sh_reg_we", reg_we_o, 1'b0);
        run_tx(1'b1, 4'h2, 32'h8000_0001, 32'h0, 32'h0, 1'b1, 5'd4, 32'h0, 0, 1, 1'b0);
        chk("lw_mis_cause", exc_cause_o, 2'd1);
        run_tx(1'b1, 4'hA, 32'h8000_0002, 32'h0, 32'h0, 1'b1, 5'd4, 32'h0, 0, 1, 1'b0);
        chk("sw_mis_cause", exc_cause_o, 2'd2);
        run_tx(1'b1, 4'h2, 32'h8000_0010, 32'h0, 32'h1357_9BDF, 1'b1, 5'd9, 32'h0, 3, 2, 1'b0);
        chk("gnt_hold_cycles", n_req_hi, 4);
        run_tx(1'b1, 4'h1, 32'h8000_0012, 32'h0, 32'hC0DE_0000, 1'b1, 5'd9, 32'h0, 0, 0, 1'b0);
        run_tx(1'b1, 4'h2, 32'h8000_0020, 32'h0, 32'h0, 1'b1, 5'd9, 32'h0, 1, 1, 1'b1);

        // timeout: grant at once, never respond
        memory_addr_i = 32'h8000_0040; ls_type_i = 4'h2; ls_valid_i = 1'b1;
        reg_we_i = 1'b1; ex_valid_i = 1'b1;
        @(posedge clk); #1;
        ex_valid_i = 1'b0; mem_gnt_i = 1'b1;
        n = 0;
        while (n < TO + 20) begin
            @(posedge clk); #1;
            mem_gnt_i = 1'b0;
            n++;
            if (wb_valid_o) break;
        end
        chk("to_cycles", n, TO);
        chk("to_exc", exc_o, 1'b1);
        chk("to_cause", exc_cause_o, 2'd3);
        chk("to_reg_we", reg_we_o, 1'b0);
        @(posedge clk); #1;

        // reset during REQ
        memory_addr_i = 32'h8000_0080; ls_type_i = 4'h2; ls_valid_i = 1'b1; ex_valid_i = 1'b1;
        @(posedge clk); #1;
        ex_valid_i = 1'b0; ls_valid_i = 1'b0;
        chk("rreq_pre", mem_req_o, 1'b1);
        rst_n = 1'b0; #1;
        chk("rreq_req", mem_req_o, 1'b0);
        chk("rreq_stall", stallreq_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // reset during WAIT, then a late response
        memory_addr_i = 32'h8000_0084; ls_valid_i = 1'b1; ex_valid_i = 1'b1;
        @(posedge clk); #1;
        ex_valid_i = 1'b0; ls_valid_i = 1'b0; mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        rst_n = 1'b0; #1;
        chk("rwait_req", mem_req_o, 1'b0);
        chk("rwait_wbv", wb_valid_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late_rvalid_wbv", wb_valid_o, 1'b0);
            @(posedge clk); #1;
        end

        // random bundles
        for (int i = 0; i < 150; i++) begin
            t = types_arr[$urandom_range(0, 7)];
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_tx(1'($urandom_range(0, 3) != 0), t, a, $urandom, $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
